// File: rtl/fifo_rd_stream_adapter_if.sv
// FIFO read-side and downstream stream signals of fifo_rd_stream_adapter.
// master = adapter view, slave = FIFO/consumer environment view.
interface fifo_rd_stream_adapter_if #(
    parameter int P_DATA_WIDTH  = 8,
    parameter int P_FIFO_DEPTH  = 16,
    parameter int P_FIFO_DWIDTH = $clog2(P_FIFO_DEPTH)
);
    logic [P_FIFO_DWIDTH:0]  i_fifo_level;
    logic                    o_fifo_rden;
    logic [P_DATA_WIDTH-1:0] i_fifo_rdata;
    logic                    i_fifo_rddata_valid;
    logic                    o_m_valid;
    logic [P_DATA_WIDTH-1:0] o_m_data;
    logic                    i_m_ready;
    logic                    o_busy;
    logic                    o_err;

    modport master (
        input  i_fifo_level, i_fifo_rdata, i_fifo_rddata_valid, i_m_ready,
        output o_fifo_rden, o_m_valid, o_m_data, o_busy, o_err
    );

    modport slave (
        output i_fifo_level, i_fifo_rdata, i_fifo_rddata_valid, i_m_ready,
        input  o_fifo_rden, o_m_valid, o_m_data, o_busy, o_err
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the FIFO pulse-read interface (rden -> data one cycle later) into a
// valid/ready stream using an in-flight flag and a 2-entry skid buffer.
module fifo_rd_stream_adapter #(
    parameter int P_DATA_WIDTH  = 8,
    parameter int P_FIFO_DEPTH  = 16,
    parameter int P_FIFO_DWIDTH = $clog2(P_FIFO_DEPTH)
) (
    input logic                     i_clk,
    input logic                     i_rst,
    fifo_rd_stream_adapter_if.master bus
);
    logic [1:0]              buf_cnt_q, buf_cnt_d;
    logic                    inflight_q;
    logic [P_DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [P_DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                    err_q;

    logic       pop;
    logic       push;
    logic       spurious;
    logic       rden;
    logic [1:0] occ_after_pop;

    always_comb begin
        pop           = (buf_cnt_q != 2'd0) & bus.i_m_ready;
        // pop implies buf_cnt_q >= 1, so this never underflows
        occ_after_pop = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        rden          = ~i_rst & (bus.i_fifo_level != '0) & (occ_after_pop < 2'd2);
        push          = bus.i_fifo_rddata_valid & inflight_q;
        spurious      = bus.i_fifo_rddata_valid & ~inflight_q;
    end

    always_comb begin
        buf_cnt_d = buf_cnt_q;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        unique case ({push, pop})
            2'b10: begin
                buf_cnt_d = buf_cnt_q + 2'd1;
                if (buf_cnt_q == 2'd0) buf0_d = bus.i_fifo_rdata;
                else                   buf1_d = bus.i_fifo_rdata;
            end
            2'b01: begin
                buf_cnt_d = buf_cnt_q - 2'd1;
                buf0_d    = buf1_q;
            end
            2'b11: begin
                // head shifts out, new word lands at the post-shift tail
                if (buf_cnt_q == 2'd1) begin
                    buf0_d = bus.i_fifo_rdata;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = bus.i_fifo_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            buf_cnt_q  <= '0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            buf_cnt_q  <= buf_cnt_d;
            inflight_q <= rden;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            err_q      <= err_q | spurious;
        end
    end

    assign bus.o_fifo_rden = rden;
    assign bus.o_m_valid   = (buf_cnt_q != 2'd0);
    assign bus.o_m_data    = buf0_q;
    assign bus.o_busy      = (buf_cnt_q != 2'd0) | inflight_q;
    assign bus.o_err       = err_q;

    a_occupancy: assert property (@(posedge i_clk) disable iff (i_rst)
        ({1'b0, buf_cnt_q} + {2'b00, inflight_q}) <= 3'd2);

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: behavioural FIFO + queue scoreboard,
// directed latency/backpressure/error checks and a randomized ready phase.
module tb_fifo_rd_stream_adapter;
    localparam int W = 8;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_stream_adapter_if #(.P_DATA_WIDTH(W), .P_FIFO_DEPTH(D)) bus ();

    fifo_rd_stream_adapter #(.P_DATA_WIDTH(W), .P_FIFO_DEPTH(D)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    logic         pend_v = 1'b0;
    logic [W-1:0] pend_d = '0;
    int           n_vec = 0;
    int           n_err = 0;
    int           occ = 0;
    int           ready_mode = 1;
    bit           force_spur = 1'b0;
    bit           rst_req = 1'b1;
    logic         s_rden, s_valid, s_busy, s_err;
    logic [W-1:0] s_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: FIFO model drives its registered outputs at the negedge,
    // then the adapter's pre-edge outputs are sampled.
    task automatic cycle();
        logic rdy;
        @(negedge clk);
        rst = rst_req;
        bus.i_fifo_level = 5'(fifo_q.size());
        if (force_spur) begin
            bus.i_fifo_rddata_valid = 1'b1;
            bus.i_fifo_rdata        = 8'hEE;
        end else begin
            bus.i_fifo_rddata_valid = pend_v;
            bus.i_fifo_rdata        = pend_v ? pend_d : 8'($urandom);
        end
        rdy = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        bus.i_m_ready = rdy;
        #1;
        s_rden  = bus.o_fifo_rden;
        s_valid = bus.o_m_valid;
        s_data  = bus.o_m_data;
        s_busy  = bus.o_busy;
        s_err   = bus.o_err;
        pend_v  = 1'b0;
        if (rst) begin
            chk("rden_in_reset", 32'(s_rden), 0);
            occ = 0;
        end else begin
            if (s_rden) begin
                if (fifo_q.size() == 0) chk("rden_on_empty", 1, 0);
                else begin
                    pend_d = fifo_q.pop_front();
                    pend_v = 1'b1;
                end
            end
            occ = occ + int'(s_rden) - int'(s_valid & rdy);
            chk("occupancy_le_2", 32'(occ <= 2 && occ >= 0), 1);
        end
    endtask

    task automatic put(input logic [W-1:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || s_busy) && n < 200) begin
            cycle();
            n++;
        end
        chk(name, 32'(n < 200), 1);
    endtask

    // Scoreboard monitor: consumes a beat whenever valid & ready.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.o_m_valid && bus.i_m_ready) begin
                if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(bus.o_m_data), 32'(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_v, last_v, nv, nr;
        bus.i_fifo_level        = '0;
        bus.i_fifo_rdata        = '0;
        bus.i_fifo_rddata_valid = 1'b0;
        bus.i_m_ready           = 1'b1;

        // Reset with a non-empty FIFO
        for (int i = 0; i < 5; i++) put(8'(8'h50 + i));
        rst_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("rst_valid", 32'(s_valid), 0);
            chk("rst_data", 32'(s_data), 0);
            chk("rst_busy", 32'(s_busy), 0);
            chk("rst_err", 32'(s_err), 0);
        end
        rst_req = 1'b0;
        cycle();
        chk("rden_after_release", 32'(s_rden), 1);
        cycle();
        chk("latency_t1_valid", 32'(s_valid), 0);
        cycle();
        chk("latency_t2_valid", 32'(s_valid), 1);
        drain("drain_reset_words");

        // Single word
        put(8'hA5);
        cycle();
        chk("single_rden", 32'(s_rden), 1);
        cycle();
        chk("single_rden_off", 32'(s_rden), 0);
        chk("single_t1_valid", 32'(s_valid), 0);
        cycle();
        chk("single_t2_valid", 32'(s_valid), 1);
        chk("single_t2_data", 32'(s_data), 32'h A5);
        cycle();
        chk("single_after_valid", 32'(s_valid), 0);
        chk("single_after_busy", 32'(s_busy), 0);

        // Streaming 16 words at full rate
        for (int i = 0; i < 16; i++) put(8'(i));
        first_v = -1; last_v = -1; nv = 0; nr = 0;
        for (int i = 0; i < 22; i++) begin
            cycle();
            nr += int'(s_rden);
            if (s_valid) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                nv++;
            end
        end
        chk("stream_rden_count", 32'(nr), 16);
        chk("stream_beats", 32'(nv), 16);
        chk("stream_first", 32'(first_v), 2);
        chk("stream_no_gap", 32'(last_v - first_v + 1), 16);

        // Backpressure
        for (int i = 0; i < 16; i++) put(8'(i));
        ready_mode = 0;
        nr = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            nr += int'(s_rden);
            if (i >= 2) begin
                chk("bp_valid_held", 32'(s_valid), 1);
                chk("bp_data_stable", 32'(s_data), 0);
            end
        end
        chk("bp_rden_count", 32'(nr), 2);
        ready_mode = 1;
        drain("drain_backpressure");

        // Random ready with random FIFO fill
        ready_mode = 2;
        begin
            int left, n;
            left = 200; n = 0;
            while ((left > 0 || exp_q.size() != 0 || s_busy) && n < 3000) begin
                if (left > 0 && fifo_q.size() < D && $urandom_range(0, 1) == 1) begin
                    put(8'($urandom));
                    left--;
                end
                cycle();
                n++;
            end
            chk("random_complete", 32'(n < 3000), 1);
        end
        ready_mode = 1;

        // Unexpected rddata_valid sets a sticky error
        cycle();
        chk("err_clear_before", 32'(s_err), 0);
        force_spur = 1'b1;
        cycle();
        force_spur = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("err_sticky", 32'(s_err), 1);
            chk("err_no_beat", 32'(s_valid), 0);
        end

        // Reset the cycle after a read: in-flight word is discarded
        put(8'h3C);
        cycle();
        chk("midrst_rden", 32'(s_rden), 1);
        rst_req = 1'b1;
        exp_q.delete();
        cycle();
        cycle();
        rst_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("midrst_valid", 32'(s_valid), 0);
            chk("midrst_err", 32'(s_err), 0);
            chk("midrst_busy", 32'(s_busy), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
